// File: rtl/clk_div_pkg.sv
`default_nettype none
// clk_div_pkg: shared defaults and width helper for the programmable clock divider family.
// rev 1.0
package clk_div_pkg;

   localparam int DIV_W_DEF       = 27;
   localparam int DEFAULT_DIV_DEF = 100;

   // Returns the select width for 'value' entries, never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prog_clock_div_if.sv
`default_nettype none
// prog_clock_div_if: control and output bundle of the multi-channel tick generator.
// rev 1.0
interface prog_clock_div_if
   import clk_div_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = DIV_W_DEF
);
   localparam int CH_W = clog2(NUM_CH);

   logic [NUM_CH-1:0] en;
   logic              sync;
   logic              wr_en;
   logic [CH_W-1:0]   wr_ch;
   logic [DIV_W-1:0]  wr_div;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;
   logic [NUM_CH-1:0] pending;

   modport master (
      output en, sync, wr_en, wr_ch, wr_div,
      input  tick, sq, pending
   );

   modport slave (
      input  en, sync, wr_en, wr_ch, wr_div,
      output tick, sq, pending
   );

endinterface
`default_nettype wire

// File: rtl/prog_div_channel.sv
`default_nettype none
// prog_div_channel: one divider channel with counter, active/shadow divisor and output flops.
// rev 1.0
module prog_div_channel
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             tick,
   output logic             sq,
   output logic             pending
);

   logic [DIV_W-1:0] count;
   logic [DIV_W-1:0] active_div;
   logic [DIV_W-1:0] shadow_div;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] wr_val;
   logic             pend;
   logic             at_term;

   always_comb begin
      div_eff = (active_div == '0) ? DIV_W'(1) : active_div;
      wr_val  = (wr_div == '0) ? DIV_W'(1) : wr_div;
      at_term = (count == (div_eff - DIV_W'(1)));
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         count      <= '0;
         active_div <= DIV_W'(DEFAULT_DIV);
         shadow_div <= DIV_W'(DEFAULT_DIV);
         pend       <= 1'b0;
         tick       <= 1'b0;
         sq         <= 1'b0;
      end else if (sync || !en) begin
         // Idle or restarting: nothing is mid-period, so divisors take effect at once.
         count <= '0;
         tick  <= 1'b0;
         sq    <= 1'b0;
         pend  <= 1'b0;
         if (wr) begin
            active_div <= wr_val;
            shadow_div <= wr_val;
         end else if (pend) begin
            active_div <= shadow_div;
         end
      end else begin
         if (at_term) begin
            count <= '0;
            tick  <= 1'b1;
            sq    <= ~sq;
            if (pend) active_div <= shadow_div;
         end else begin
            count <= count + DIV_W'(1);
            tick  <= 1'b0;
         end
         // A write landing on the wrap becomes the next shadow, after the old one was applied.
         if (wr) begin
            shadow_div <= wr_val;
            pend       <= 1'b1;
         end else if (at_term) begin
            pend <= 1'b0;
         end
      end
   end

   assign pending = pend;

endmodule
`default_nettype wire

// File: rtl/prog_clock_div.sv
`default_nettype none
// prog_clock_div: NUM_CH runtime-programmable tick/square generators with common sync.
// rev 1.0
module prog_clock_div
   import clk_div_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset_p,
   prog_clock_div_if.slave  bus
);

   localparam int CH_W = clog2(NUM_CH);

   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] tick_v;
   logic [NUM_CH-1:0] sq_v;
   logic [NUM_CH-1:0] pend_v;

   // Out-of-range channel numbers match no entry and are dropped.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (bus.wr_en && (bus.wr_ch == CH_W'(i))) wr_sel[i] = 1'b1;
      end
   end

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         prog_div_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_ch (
            .clk     (clk),
            .reset_p (reset_p),
            .en      (bus.en[i]),
            .sync    (bus.sync),
            .wr      (wr_sel[i]),
            .wr_div  (bus.wr_div),
            .tick    (tick_v[i]),
            .sq      (sq_v[i]),
            .pending (pend_v[i])
         );
      end
   endgenerate

   assign bus.tick    = tick_v;
   assign bus.sq      = sq_v;
   assign bus.pending = pend_v;

endmodule
`default_nettype wire

// File: tb/tb_prog_clock_div.sv
`default_nettype none
// tb_prog_clock_div: randomized + directed scoreboard bench for prog_clock_div.
// rev 1.0
module tb_prog_clock_div;

   localparam int N   = 5;
   localparam int DW  = 27;
   localparam int DEF = 100;

   typedef struct {
      int           n;
      logic [N-1:0] tick;
      logic [N-1:0] sq;
      logic [N-1:0] pend;
   } exp_t;

   logic clk;
   logic reset_p;
   prog_clock_div_if #(.NUM_CH(N), .DIV_W(DW)) bus ();

   prog_clock_div #(.NUM_CH(N), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
      .clk     (clk),
      .reset_p (reset_p),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t         expq[$];
   int           checks = 0;
   int           errors = 0;
   int           cyc    = 0;
   logic [N-1:0] cur_en = '0;

   // Reference: per channel, the edge at which the current period began; a tick is due
   // exactly div edges after that start.
   int  m_act[N];
   int  m_shd[N];
   int  m_start[N];
   bit  m_pend[N];
   bit  m_sq[N];
   bit  m_tk[N];

   task automatic check(input string name, input int n, input logic [N-1:0] got, input logic [N-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s edge=%0d got=%b want=%b", name, n, got, want);
      end
   endtask

   task automatic model(input logic [N-1:0] e, input bit s, input bit we, input int ch, input int dv, input bit r);
      int v;
      int d;
      bit wr;
      v = (dv == 0) ? 1 : dv;
      for (int i = 0; i < N; i++) begin
         wr = we && (ch == i);
         if (r) begin
            m_act[i] = DEF; m_shd[i] = DEF; m_pend[i] = 0;
            m_sq[i] = 0; m_tk[i] = 0; m_start[i] = cyc;
         end else if (s || !e[i]) begin
            m_tk[i] = 0; m_sq[i] = 0; m_start[i] = cyc;
            if (wr) m_act[i] = v;
            else if (m_pend[i]) m_act[i] = m_shd[i];
            m_pend[i] = 0;
         end else begin
            d = (m_act[i] == 0) ? 1 : m_act[i];
            if (cyc - m_start[i] == d) begin
               m_tk[i] = 1; m_sq[i] = !m_sq[i]; m_start[i] = cyc;
               if (m_pend[i]) m_act[i] = m_shd[i];
               m_pend[i] = 0;
            end else begin
               m_tk[i] = 0;
            end
            if (wr) begin m_shd[i] = v; m_pend[i] = 1; end
         end
      end
   endtask

   task automatic step(input logic [N-1:0] e, input bit s, input bit we, input int ch, input int dv, input bit r);
      exp_t x;
      @(negedge clk);
      bus.en     = e;
      bus.sync   = s;
      bus.wr_en  = we;
      bus.wr_ch  = 3'(ch);
      bus.wr_div = DW'(dv);
      reset_p    = r;
      cyc++;
      model(e, s, we, ch, dv, r);
      x.n = cyc;
      for (int i = 0; i < N; i++) begin
         x.tick[i] = m_tk[i]; x.sq[i] = m_sq[i]; x.pend[i] = m_pend[i];
      end
      expq.push_back(x);
      if (r) begin
         #1;
         check("async_rst_tick", cyc, bus.tick, '0);
         check("async_rst_sq", cyc, bus.sq, '0);
         check("async_rst_pending", cyc, bus.pending, '0);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) step(cur_en, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int ch, input int dv);
      step(cur_en, 0, 1, ch, dv, 0);
   endtask

   // Monitor: every edge produces an output vector; compare it against the oldest expectation.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            x = expq.pop_front();
            check("tick", x.n, bus.tick, x.tick);
            check("sq", x.n, bus.sq, x.sq);
            check("pending", x.n, bus.pending, x.pend);
         end
      end
   end

   initial begin
      bit s, we, r;
      int ch, dv;
      reset_p    = 1'b1;
      bus.en     = '0;
      bus.sync   = 1'b0;
      bus.wr_en  = 1'b0;
      bus.wr_ch  = '0;
      bus.wr_div = '0;
      for (int i = 0; i < N; i++) begin
         m_act[i] = DEF; m_shd[i] = DEF; m_start[i] = 0;
         m_pend[i] = 0; m_sq[i] = 0; m_tk[i] = 0;
      end
      repeat (3) step('0, 0, 0, 0, 0, 1);

      // Default divisor on channel 0.
      cur_en = 5'b00001; idle(305);
      cur_en = '0;       idle(2);

      // Channel 1 at 10, retuned to 4 mid-period.
      wr(1, 10);
      cur_en = 5'b00010; idle(3);
      wr(1, 4);          idle(30);

      // Channel 2 with divisor 0, then 1.
      cur_en = '0; wr(2, 0);
      cur_en = 5'b00100; idle(8);
      wr(2, 1);          idle(8);

      // Channels 0 and 3 out of phase, then sync, then sync with a write.
      cur_en = '0; idle(1);
      wr(0, 6); wr(3, 9);
      cur_en = 5'b00001; idle(3);
      cur_en = 5'b01001; idle(20);
      step(cur_en, 1, 0, 0, 0, 0); idle(20);
      step(cur_en, 1, 1, 3, 5, 0); idle(12);

      // Reset while a write is pending, plus out-of-range writes.
      cur_en = 5'b01011; idle(5);
      wr(1, 7); idle(2);
      step(cur_en, 0, 1, 5, 3, 1);
      step(cur_en, 0, 1, 7, 3, 1);
      cur_en = '0;
      step(cur_en, 0, 1, 5, 3, 0);
      step(cur_en, 0, 1, 6, 2, 0);
      cur_en = '1; idle(105);

      // Drop channel 1 enable one edge before its terminal count.
      cur_en = '0; idle(1);
      wr(1, 8);
      cur_en = 5'b00010; idle(6);
      cur_en = '0;       idle(1);
      cur_en = 5'b00010; idle(12);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(15) == 0) cur_en[$urandom_range(N-1)] ^= 1'b1;
         we = ($urandom_range(3) == 0);
         ch = $urandom_range(7);
         dv = $urandom_range(12);
         s  = ($urandom_range(39) == 0);
         r  = ($urandom_range(299) == 0);
         step(cur_en, s, we, ch, dv, r);
      end

      cur_en = '0; idle(1);
      repeat (3) @(negedge clk);
      check("queue_drained", cyc, 5'(expq.size()), '0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/prog_clock_div.md
# prog_clock_div

Multi-channel programmable tick generator, the runtime-configurable successor to the fixed-ratio dividers. Each of `NUM_CH` channels divides the system clock by a divisor written at run time. Each channel produces a one-cycle `tick` strobe and a 50 % duty `sq` toggle output. Divisor changes are glitch-free, and a common `sync` input phase-aligns all channels. It sits between the system clock and the timing consumers: the PWM, the debouncers, the FND scan and the timer blocks.

## Interface
- `NUM_CH`, 4: number of independent channels (≥1).
- `DIV_W`, 27: divisor/counter width in bits.
- `DEFAULT_DIV`, 100: active divisor of every channel after reset (1 … 2^DIV_W−1).
- `CH_W`, derived `clog2(NUM_CH)`, minimum 1: channel-select width.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `reset_p`  in  1: asynchronous, active-high reset.
- `en`  in  NUM_CH: per-channel enable, level.
- `sync`  in  1: one-cycle strobe that restarts all channels together.
- `wr_en`  in  1: divisor write strobe.
- `wr_ch`  in  CH_W: target channel. Values ≥ NUM_CH are ignored.
- `wr_div`  in  DIV_W: new divisor. 0 is treated as 1.
- `tick`  out  NUM_CH: registered one-cycle strobe per divide period.
- `sq`  out  NUM_CH: registered square wave with period 2·div.
- `pending`  out  NUM_CH: a written divisor is waiting to be applied.

## Operation
- Per-channel state:
  - `count` (DIV_W).
  - `active_div` (DIV_W).
  - `shadow_div` (DIV_W).
  - `pend` flag (drives `pending`).
- Effective divisor: `div_eff = (active_div == 0) ? 1 : active_div`. The stored `wr_div` value is clamped the same way.
- Channel enabled, no `sync`:
  - If `count == div_eff−1`: `count <= 0`, `tick <= 1`, `sq <= ~sq`. In the same cycle, if `pend`, then `active_div <= shadow_div` and `pend <= 0`.
  - Otherwise: `count <= count+1`, `tick <= 0`.
- Channel disabled (`en[i]=0`):
  - `count`, `tick` and `sq` are all cleared to 0.
  - Any pending shadow is applied immediately.
  - A write goes straight to `active_div` and `pend` stays 0.
- Write to an enabled channel: the value goes to `shadow_div` and `pend <= 1`. A second write before application overwrites the shadow; the last write wins.
- Write on the same cycle as that channel's terminal count: the currently pending value (if any) is applied, and the new write becomes the shadow with `pend=1`.
- `sync`, all channels:
  - `count <= 0`, `tick <= 0`, `sq <= 0`.
  - Pending shadows are applied.
  - A simultaneous `wr_en` is applied directly to `active_div` (write wins), leaving `pend=0`.
- `div_eff == 1`: `tick` is held high continuously while enabled, and `sq` toggles every cycle.
- Counter never exceeds `div_eff−1`, because the divisor changes only at the wrap. Wrap-around past 2^DIV_W is impossible.

## Timing
- Reset values:
  - Outputs: `tick=0`, `sq=0`, `pending=0`.
  - Internal state: `count=0`, `active_div=shadow_div=DEFAULT_DIV`.
- First tick is registered at the `div_eff`-th rising edge on which `en[i]` is sampled high (or the `div_eff`-th edge after `sync`). Ticks then repeat every `div_eff` cycles.
- New divisor on an enabled channel: the remaining cycles of the current period complete at the old divisor. The next period uses the new one. `pending` falls on the same edge that `tick` rises.
- `en` falling: `tick` and `sq` are 0 from the next edge. There is no partial tick.
- `reset_p` mid-period clears asynchronously. No tick is emitted on release.
- Zero combinational paths from inputs to outputs.

## Structure
- Shared package/header `clk_div_pkg`:
  - `DIV_W` default.
  - `clog2` function.
  - `DEFAULT_DIV` constant.
- Sub-module `prog_div_channel`:
  - Holds one channel's counter, active/shadow registers and output flops.
  - Inputs: `en`, `sync`, `wr` (already decoded), `wr_div`.
  - The top level instantiates `NUM_CH` copies in a generate loop and does the `wr_ch` decode.

## Test plan
- Reset, then `en[0]=1`, default div 100 → `tick[0]` high for one cycle at edges 100, 200, 300; `sq[0]` toggles at each; `pending=0`.
- Channel 1 enabled at div 10; write 4 at count 3 → `pending[1]=1`; ticks at 10 (pending drops) and then every 4 cycles.
- Write 0 to disabled channel 2, enable → `tick[2]` constant 1, `sq[2]` toggles every cycle; write 1 gives identical behaviour.
- Channels 0 and 3 at divs 6 and 9, running out of phase; pulse `sync` → both counts reset; ticks at sync+6 and sync+9 respectively; `sync` with `wr_en` to channel 3 (div 5) → channel 3 ticks at sync+5 and `pending[3]=0`.
- Assert `reset_p` mid-period while a write is pending; `wr_ch=NUM_CH` write → all outputs are 0 immediately; after release, divisors equal `DEFAULT_DIV`; the out-of-range write changes no channel.
- Drop `en[1]` one cycle before its terminal count → no tick; re-enable → first tick after a full `div_eff` cycles.
